// File: rtl/inst_issue_queue_pkg.sv
// Shared types for the instruction issue queue: operand/opcode widths,
// register file size and the packed instruction record kept in the FIFO.
package inst_issue_queue_pkg;

  localparam int NUM_REGS = 4;

  typedef logic [3:0] t_opcode;
  typedef logic [7:0] t_data;
  typedef logic [1:0] t_reg_name;

  typedef struct packed {
    t_opcode   opcode;
    t_data     imm;
    t_reg_name src1;
    t_reg_name src2;
    t_reg_name dst;
  } t_inst;

  // One-hot mask selecting a single register in the pending bitmap.
  function automatic logic [NUM_REGS-1:0] reg_mask(t_reg_name r);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/inst_issue_queue_if.sv
// Bundle of the issue queue's front-end, issue and writeback signals.
// master = the environment driving instructions/writebacks; slave = the queue.
interface inst_issue_queue_if
  import inst_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic                instv;
  t_opcode             opcode;
  t_data               imm;
  t_reg_name           src1;
  t_reg_name           src2;
  t_reg_name           dst;
  logic                in_ready;
  logic                overflow;
  logic                iss_valid;
  logic                iss_ready;
  t_opcode             iss_opcode;
  t_data               iss_imm;
  t_reg_name           iss_src1;
  t_reg_name           iss_src2;
  t_reg_name           iss_dst;
  logic                wb_valid;
  t_reg_name           wb_dst;
  logic [NUM_REGS-1:0] pending;
  logic [CNT_W-1:0]    count;

  modport master (
    output instv, opcode, imm, src1, src2, dst, iss_ready, wb_valid, wb_dst,
    input  in_ready, overflow, iss_valid, iss_opcode, iss_imm, iss_src1,
           iss_src2, iss_dst, pending, count
  );

  modport slave (
    input  instv, opcode, imm, src1, src2, dst, iss_ready, wb_valid, wb_dst,
    output in_ready, overflow, iss_valid, iss_opcode, iss_imm, iss_src1,
           iss_src2, iss_dst, pending, count
  );
endinterface

// File: rtl/inst_issue_queue_fifo.sv
// Generic DEPTH-entry synchronous FIFO of t_inst. Payload is not reset;
// pointers wrap naturally because DEPTH is a power of two.
module inst_fifo
  import inst_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  t_inst            wdata,
  input  logic             pop,
  output t_inst            rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  t_inst            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Payload write; storage carries no reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_issue_queue.sv
// In-order instruction issue queue: FIFO buffering plus a per-register
// pending-write scoreboard that stalls the head on RAW/WAW hazards.
module inst_issue_queue
  import inst_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic               clock,
  input logic               reset,
  inst_issue_queue_if.slave bus
);
  t_inst               wr_inst, head;
  logic                full, empty, push, fire, hazard, issuable;
  logic [NUM_REGS-1:0] pending, pending_nxt;
  logic                overflow;
  logic [CNT_W-1:0]    count;

  assign wr_inst = '{opcode: bus.opcode, imm: bus.imm, src1: bus.src1,
                     src2: bus.src2, dst: bus.dst};

  // A full queue refuses pushes even if the head leaves this cycle.
  assign push     = bus.instv && !full;
  assign hazard   = pending[head.src1] | pending[head.src2] | pending[head.dst];
  assign issuable = !empty && !hazard;
  assign fire     = issuable && bus.iss_ready;

  inst_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (wr_inst),
    .pop   (fire),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Scoreboard update: writeback clears, issue sets; set applied last so it wins.
  always_comb begin
    pending_nxt = pending;
    if (bus.wb_valid) pending_nxt = pending_nxt & ~reg_mask(bus.wb_dst);
    if (fire)         pending_nxt = pending_nxt | reg_mask(head.dst);
  end

  // Scoreboard register and the one-cycle dropped-instruction flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      overflow <= bus.instv && full;
    end
  end

  assign bus.in_ready   = !full;
  assign bus.overflow   = overflow;
  assign bus.iss_valid  = issuable;
  assign bus.iss_opcode = head.opcode;
  assign bus.iss_imm    = head.imm;
  assign bus.iss_src1   = head.src1;
  assign bus.iss_src2   = head.src2;
  assign bus.iss_dst    = head.dst;
  assign bus.pending    = pending;
  assign bus.count      = count;

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed bench for inst_issue_queue: accepted pushes feed an expected-issue
// queue, a negedge monitor pops and compares on every fire; state checks inline.
module tb_inst_issue_queue;
  import inst_issue_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  inst_issue_queue_if #(.DEPTH(DEPTH)) ifc ();

  inst_issue_queue #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clock = ~clock;

  int    n_chk  = 0;
  int    n_fail = 0;
  t_inst sb[$];
  t_inst mon_got, mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present an instruction; record it as expected if the queue will take it.
  task automatic drive(input int op, input int im, input int s1, input int s2, input int d);
    t_inst x;
    x = '{opcode: t_opcode'(op), imm: t_data'(im), src1: t_reg_name'(s1),
          src2: t_reg_name'(s2), dst: t_reg_name'(d)};
    ifc.opcode = x.opcode;
    ifc.imm    = x.imm;
    ifc.src1   = x.src1;
    ifc.src2   = x.src2;
    ifc.dst    = x.dst;
    ifc.instv  = 1'b1;
    if (ifc.in_ready) sb.push_back(x);
  endtask

  // Monitor: every fire must match the oldest accepted instruction.
  always @(negedge clock) begin
    if (reset && ifc.iss_valid && ifc.iss_ready) begin
      mon_got = '{opcode: ifc.iss_opcode, imm: ifc.iss_imm, src1: ifc.iss_src1,
                  src2: ifc.iss_src2, dst: ifc.iss_dst};
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL issue_unexpected: got %0h expected nothing at %0t", mon_got, $time);
      end else begin
        mon_exp = sb.pop_front();
        chk("issue_fields", 32'(mon_got), 32'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.instv = 0; ifc.opcode = '0; ifc.imm = '0; ifc.src1 = '0; ifc.src2 = '0;
    ifc.dst = '0; ifc.iss_ready = 0; ifc.wb_valid = 0; ifc.wb_dst = '0;

    // Reset state
    #12;
    chk("rst_iss_valid", 32'(ifc.iss_valid), 0);
    chk("rst_in_ready", 32'(ifc.in_ready), 1);
    chk("rst_count", 32'(ifc.count), 0);
    chk("rst_pending", 32'(ifc.pending), 0);
    chk("rst_overflow", 32'(ifc.overflow), 0);
    @(negedge clock); reset = 1'b1;
    tick();
    chk("rel_iss_valid", 32'(ifc.iss_valid), 0);
    chk("rel_in_ready", 32'(ifc.in_ready), 1);

    // Single issue
    ifc.iss_ready = 1;
    drive(1, 'h5A, 0, 1, 2); tick(); ifc.instv = 0;
    chk("single_valid", 32'(ifc.iss_valid), 1);
    chk("single_count", 32'(ifc.count), 1);
    tick();
    chk("single_pending", 32'(ifc.pending), 'h4);
    chk("single_count0", 32'(ifc.count), 0);

    // RAW stall on r2
    drive(2, 'h11, 2, 0, 1); tick(); ifc.instv = 0;
    chk("raw_stall", 32'(ifc.iss_valid), 0);
    chk("raw_count", 32'(ifc.count), 1);
    tick(); tick();
    chk("raw_stall2", 32'(ifc.iss_valid), 0);
    chk("raw_pending", 32'(ifc.pending), 'h4);
    ifc.wb_valid = 1; ifc.wb_dst = 2; tick(); ifc.wb_valid = 0;
    chk("raw_release", 32'(ifc.iss_valid), 1);
    chk("raw_pending_clr", 32'(ifc.pending), 0);
    tick();
    chk("raw_pending_r1", 32'(ifc.pending), 'h2);
    chk("raw_count0", 32'(ifc.count), 0);
    ifc.wb_valid = 1; ifc.wb_dst = 1; tick(); ifc.wb_valid = 0;
    chk("raw_clean", 32'(ifc.pending), 0);

    // Fill and overflow
    ifc.iss_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive(3 + i, 'hA0 + i, i, i, i); tick();
    end
    ifc.instv = 0;
    chk("fill_count", 32'(ifc.count), 4);
    chk("fill_in_ready", 32'(ifc.in_ready), 0);
    chk("fill_no_ovf", 32'(ifc.overflow), 0);
    drive(8, 'hFF, 0, 0, 0); tick(); ifc.instv = 0;
    chk("ovf_pulse", 32'(ifc.overflow), 1);
    chk("ovf_count", 32'(ifc.count), 4);
    tick();
    chk("ovf_clear", 32'(ifc.overflow), 0);
    ifc.iss_ready = 1;
    repeat (4) tick();
    chk("drain_count", 32'(ifc.count), 0);
    chk("drain_pending", 32'(ifc.pending), 'hF);
    for (int r = 0; r < 4; r++) begin
      ifc.wb_valid = 1; ifc.wb_dst = t_reg_name'(r); tick();
    end
    ifc.wb_valid = 0;
    chk("drain_clean", 32'(ifc.pending), 0);

    // Issue and writeback hit r3 on the same edge: set wins
    ifc.iss_ready = 0;
    drive(7, 'hB0, 0, 0, 3); tick(); ifc.instv = 0;
    ifc.iss_ready = 1; ifc.wb_valid = 1; ifc.wb_dst = 3; tick(); ifc.wb_valid = 0;
    chk("collide_pending", 32'(ifc.pending), 'h8);
    chk("collide_count", 32'(ifc.count), 0);
    ifc.wb_valid = 1; tick(); ifc.wb_valid = 0;
    chk("collide_clean", 32'(ifc.pending), 0);

    // Concurrent push and pop at count 2 across three pointer wraps
    ifc.iss_ready = 0;
    drive(9, 'h20, 0, 0, 0); tick();
    drive(9, 'h21, 1, 1, 1); tick(); ifc.instv = 0;
    chk("conc_count_init", 32'(ifc.count), 2);
    for (int i = 0; i < 12; i++) begin
      drive(10, 'h30 + i, (i + 2) % 4, (i + 2) % 4, (i + 2) % 4);
      ifc.iss_ready = 1;
      if (i > 0) begin
        ifc.wb_valid = 1; ifc.wb_dst = t_reg_name'((i - 1) % 4);
      end
      tick();
      chk("conc_count", 32'(ifc.count), 2);
    end
    ifc.instv = 0;
    ifc.wb_valid = 1; ifc.wb_dst = 3; tick();
    ifc.wb_dst = 0; tick();
    ifc.wb_dst = 1; tick();
    ifc.wb_valid = 0;
    chk("conc_count_end", 32'(ifc.count), 0);
    chk("conc_pending_end", 32'(ifc.pending), 0);

    // Reset mid-stream with count=3, pending=1010
    drive(11, 'h40, 1, 1, 1); tick();
    drive(12, 'h41, 3, 3, 3); tick(); ifc.instv = 0;
    tick();
    ifc.iss_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive(13, 'h50 + i, 0, 0, 0); tick();
    end
    ifc.instv = 0;
    chk("mid_count", 32'(ifc.count), 3);
    chk("mid_pending", 32'(ifc.pending), 'hA);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_count", 32'(ifc.count), 0);
    chk("mid_rst_pending", 32'(ifc.pending), 0);
    chk("mid_rst_valid", 32'(ifc.iss_valid), 0);
    chk("mid_rst_in_ready", 32'(ifc.in_ready), 1);
    sb.delete();
    @(negedge clock); reset = 1'b1;
    ifc.iss_ready = 1;
    tick();
    chk("post_rst_valid", 32'(ifc.iss_valid), 0);
    drive(14, 'h60, 1, 3, 2); tick(); ifc.instv = 0;
    chk("post_rst_issue", 32'(ifc.iss_valid), 1);
    tick();
    chk("post_rst_count", 32'(ifc.count), 0);
    chk("post_rst_pending", 32'(ifc.pending), 'h4);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_issue_queue.md
Name: inst_issue_queue

Overview:
- Buffers instructions from the global-inputs interface (instv/opcode/imm/src1/src2/dst) in a small FIFO.
- Issues them in order to the execution core over a valid/ready handshake.
- Holds back any instruction whose registers are still awaiting writeback, using a per-register pending scoreboard.
- Sits directly downstream of the inputs interface and directly upstream of the execute/writeback datapath.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
instv  in  1  new instruction valid this cycle.
opcode  in  t_opcode  instruction opcode.
imm  in  t_data  immediate operand.
src1  in  t_reg_name  first source register.
src2  in  t_reg_name  second source register.
dst  in  t_reg_name  destination register.
in_ready  out  1  queue can accept; equals !full.
overflow  out  1  one-cycle pulse: instv arrived while full and the instruction was dropped.
iss_valid  out  1  head instruction is issuable.
iss_ready  in  1  core accepts the head instruction.
iss_opcode, iss_imm, iss_src1, iss_src2, iss_dst  out  package types  fields of the head entry.
wb_valid  in  1  core retires a write this cycle.
wb_dst  in  t_reg_name  register being retired.
pending  out  NUM_REGS  scoreboard bitmap; bit r set means register r has an in-flight write.
count  out  CNT_W  current occupancy.

Behaviour:
- Reset:
  - reset low asynchronously clears read/write pointers, count, pending and overflow.
  - iss_valid=0 and in_ready=1 while reset is asserted and after release.
  - FIFO payload storage is not reset; iss_* fields are don't-care while iss_valid=0.
- Push:
  - An instruction is accepted on a clock edge when instv && !full.
  - It is written at the write pointer, which increments modulo DEPTH.
  - instv && full drops the instruction and drives overflow=1 for exactly the next cycle; the FIFO state is unchanged.
- Full and pop: in_ready is !full only. No push is accepted while full, even when a pop occurs in the same cycle.
- Issue:
  - iss_valid = !empty && !hazard, combinational from the registered state.
  - hazard = pending[head.src1] | pending[head.src2] | pending[head.dst]. This covers RAW and WAW.
  - Fire = iss_valid && iss_ready. On fire the read pointer increments modulo DEPTH and pending[head.dst] is set.
  - iss_* fields are driven from the head entry whenever the queue is non-empty.
  - Strict in-order issue: a stalled head blocks all younger entries.
- Latency: an instruction pushed into an empty queue with no hazard presents iss_valid on the cycle after the push edge, a minimum of 1 cycle. The queue never bypasses same-cycle inputs.
- Writeback:
  - wb_valid clears pending[wb_dst] at the clock edge.
  - A clear becomes visible to the hazard check on the next cycle; there is no same-cycle bypass.
  - If the same register is cleared by writeback and set by an issue in the same cycle, the set wins.
  - wb_valid for a register that is not pending is harmless and leaves it at 0.
- Simultaneous push and pop when neither full nor empty: both are performed and count is unchanged.
- Count: count tracks occupancy 0..DEPTH. full = (count==DEPTH) and empty = (count==0).
- Reset mid-operation: all queued instructions and pending bits are discarded immediately. No issue occurs on the cycle reset is released.

Decomposition:
- Shared package provides t_opcode (4 bits), t_data (8 bits), t_reg_name (2 bits), NUM_REGS=4, and a packed struct t_inst {opcode, imm, src1, src2, dst} used for FIFO storage and the iss_* bundle.
- One sub-module is natural: inst_fifo, a generic DEPTH-entry synchronous FIFO of t_inst with push/pop/full/empty/count.
- Scoreboard and issue logic stay in the top level.

Test Plan:
- Reset and single issue: release reset, push {opcode=1, imm=8'h5A, src1=0, src2=1, dst=2} with iss_ready=1 → iss_valid the next cycle with those fields, fire, pending=4'b0100, count returns to 0.
- RAW stall:
  - Stimulus: issue dst=2 with no writeback, then push src1=2.
  - Required stall: iss_valid=0 while pending[2]=1.
  - Release: pulse wb_valid with wb_dst=2, and iss_valid=1 exactly one cycle after that edge.
- Fill and overflow:
  - Stimulus: iss_ready=0 with 5 consecutive pushes, DEPTH=4.
  - Required: count=4 and in_ready=0 after the fourth push; the 5th push gives overflow=1 for one cycle.
  - Drain: with iss_ready=1, the four entries issue in order once hazards are cleared.
- Collision on dst: in one cycle, issue an instruction with dst=3 while wb_valid with wb_dst=3 → pending[3]=1 afterwards.
- Concurrent push and pop: count=2, push and fire on the same edge → count stays 2 and the pointers wrap correctly across 3 wrap-arounds.
- Reset mid-stream: assert reset with count=3 and pending=4'b1010 → immediately count=0, pending=0, iss_valid=0, in_ready=1.
